// File: rtl/stall_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stall_gen_pkg : shared pipeline widths, Tuse/Tnew codes, MDU times  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package stall_gen_pkg;

   localparam int REG_W  = 5;
   localparam int TUSE_W = 2;
   localparam int TNEW_W = 2;
   localparam int CNT_W  = 4;

   typedef logic [REG_W-1:0]  reg_addr_t;
   typedef logic [TUSE_W-1:0] tuse_t;
   typedef logic [TNEW_W-1:0] tnew_t;
   typedef logic [CNT_W-1:0]  mdu_cnt_t;

   localparam tuse_t    TUSE_NONE   = 2'd3;
   localparam mdu_cnt_t MULT_CYCLES = 4'd5;
   localparam mdu_cnt_t DIV_CYCLES  = 4'd10;

   typedef struct packed {
      reg_addr_t a3;
      tnew_t     tnew;
      logic      start;
      logic      isdiv;
   } e_shadow_t;

   // A producer in E/M blocks an operand only if its value arrives after it is needed.
   function automatic logic raw_hazard(reg_addr_t x_a3, tnew_t x_tnew,
                                       reg_addr_t d_a, tuse_t d_tuse);
      return (x_a3 != '0) && (x_a3 == d_a) &&
             (d_tuse != TUSE_NONE) && (d_tuse < x_tnew);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stall_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stall_gen_if : D-stage hazard descriptors and the stall response    |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface stall_gen_if;
   import stall_gen_pkg::*;

   reg_addr_t D_A1;
   reg_addr_t D_A2;
   tuse_t     D_Tuse1;
   tuse_t     D_Tuse2;
   reg_addr_t D_A3;
   tnew_t     D_Tnew;
   logic      D_md;
   logic      D_start;
   logic      D_isdiv;
   logic      stall;

   modport master (
      output D_A1, D_A2, D_Tuse1, D_Tuse2, D_A3, D_Tnew, D_md, D_start, D_isdiv,
      input  stall
   );

   modport slave (
      input  D_A1, D_A2, D_Tuse1, D_Tuse2, D_A3, D_Tnew, D_md, D_start, D_isdiv,
      output stall
   );

endinterface
`default_nettype wire

// File: rtl/stall_gen_mdu_busy_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_busy_ctr : remaining-cycle counter for the mult/div unit        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdu_busy_ctr
   import stall_gen_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic isdiv,
   output logic busy
);

   mdu_cnt_t r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (start) begin
         r_cnt <= isdiv ? DIV_CYCLES : MULT_CYCLES;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - mdu_cnt_t'(1);
      end
   end

   assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/stall_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stall_gen : D-stage interlock for RAW data hazards and MDU busy     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module stall_gen
   import stall_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   stall_gen_if.slave  bus
);

   e_shadow_t r_e;
   reg_addr_t r_m_a3;
   tnew_t     r_m_tnew;

   logic w_busy;
   logic w_hz1;
   logic w_hz2;
   logic w_mdu;
   logic w_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e      <= '0;
         r_m_a3   <= '0;
         r_m_tnew <= '0;
      end else begin
         // A stalled D instruction leaves a bubble behind it in E.
         if (w_stall) begin
            r_e <= '0;
         end else begin
            r_e <= '{a3: bus.D_A3, tnew: bus.D_Tnew,
                     start: bus.D_start, isdiv: bus.D_isdiv};
         end
         r_m_a3   <= r_e.a3;
         r_m_tnew <= (r_e.tnew == '0) ? '0 : r_e.tnew - tnew_t'(1);
      end
   end

   mdu_busy_ctr u_busy (
      .clk   (clk),
      .reset (reset),
      .start (r_e.start),
      .isdiv (r_e.isdiv),
      .busy  (w_busy)
   );

   assign w_hz1 = raw_hazard(r_e.a3, r_e.tnew, bus.D_A1, bus.D_Tuse1) |
                  raw_hazard(r_m_a3, r_m_tnew, bus.D_A1, bus.D_Tuse1);
   assign w_hz2 = raw_hazard(r_e.a3, r_e.tnew, bus.D_A2, bus.D_Tuse2) |
                  raw_hazard(r_m_a3, r_m_tnew, bus.D_A2, bus.D_Tuse2);
   assign w_mdu = bus.D_md & (r_e.start | w_busy);

   assign w_stall   = w_hz1 | w_hz2 | w_mdu;
   assign bus.stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_stall_gen.sv
`default_nettype none
// Bench for stall_gen: directed pipeline scenarios plus random traffic,
// checked against a timestamp-based model of in-flight producers.
module tb_stall_gen;
   import stall_gen_pkg::*;

   localparam int MAXC = 8192;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stall_gen_if bus ();

   stall_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: each instruction accepted into E is logged by the cycle it entered.
   int        cyc        = 0;
   int        reset_cyc  = -1;
   bit        log_v    [MAXC];
   logic [4:0] log_a3  [MAXC];
   logic [1:0] log_tnew[MAXC];
   int        last_start = -100;
   int        last_len   = 0;

   function automatic bit model_stall();
      bit s;
      int n;
      int rem;
      s = 1'b0;
      for (int age = 0; age < 2; age++) begin
         n = cyc - age;
         if (n > reset_cyc && n >= 0 && log_v[n] && log_a3[n] != 5'd0) begin
            rem = int'(log_tnew[n]) - age;
            if (rem < 0) rem = 0;
            if (bus.D_Tuse1 != 2'd3 && bus.D_A1 == log_a3[n] && int'(bus.D_Tuse1) < rem) s = 1'b1;
            if (bus.D_Tuse2 != 2'd3 && bus.D_A2 == log_a3[n] && int'(bus.D_Tuse2) < rem) s = 1'b1;
         end
      end
      if (bus.D_md && last_start > reset_cyc && (cyc - last_start) <= last_len) s = 1'b1;
      return s;
   endfunction

   task automatic drive(input int a1, input int tu1, input int a2, input int tu2,
                        input int a3, input int tnew, input bit md, input bit start,
                        input bit isdiv);
      bus.D_A1    = 5'(a1);
      bus.D_Tuse1 = 2'(tu1);
      bus.D_A2    = 5'(a2);
      bus.D_Tuse2 = 2'(tu2);
      bus.D_A3    = 5'(a3);
      bus.D_Tnew  = 2'(tnew);
      bus.D_md    = md;
      bus.D_start = start;
      bus.D_isdiv = isdiv;
   endtask

   // Compare stall against the model, then advance one clock and update the model.
   task automatic tick(input string tag, output bit st);
      bit e;
      #1;
      e = model_stall();
      st = bus.stall;
      total++;
      assert (bus.stall === e) else begin
         bad++;
         $error("FAIL %s cyc=%0d stall observed=%b expected=%b", tag, cyc, bus.stall, e);
      end
      @(posedge clk);
      cyc++;
      if (reset) begin
         reset_cyc = cyc;
      end else if (!e) begin
         log_v[cyc]    = 1'b1;
         log_a3[cyc]   = bus.D_A3;
         log_tnew[cyc] = bus.D_Tnew;
         if (bus.D_start) begin
            last_start = cyc;
            last_len   = bus.D_isdiv ? int'(DIV_CYCLES) : int'(MULT_CYCLES);
         end
      end
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold the current D inputs and count stalled cycles until it issues.
   task automatic count_stalls(input string tag, output int n);
      bit s;
      n = 0;
      do begin
         tick(tag, s);
         if (s) n++;
      end while (s && n < 40);
      if (n >= 40) begin
         bad++;
         $display("FAIL %s timeout observed=stuck expected=release", tag);
      end
   endtask

   task automatic nops(input int k);
      bit s;
      drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
      for (int i = 0; i < k; i++) tick("nop", s);
   endtask

   initial begin : main
      bit s;
      int n;
      bit hold;

      reset = 1'b1;
      drive(8, 0, 9, 0, 8, 2, 1, 0, 0);
      tick("reset0", s);
      tick("reset1", s);
      reset = 1'b0;
      // Reset state: hazard-rich D inputs must not stall against empty shadows.
      tick("post_reset", s);
      chk("reset_state_stall", int'(s), 0);
      nops(2);

      // lw $t0 ; add using $t0 -> one bubble
      drive(0, 3, 0, 3, 8, 2, 0, 0, 0);
      tick("lw", s);
      drive(8, 1, 0, 3, 9, 1, 0, 0, 0);
      count_stalls("lw_add", n);
      chk("lw_add_stall_cycles", n, 1);
      nops(2);

      // lw $t0 ; beq using $t0 -> two stall cycles
      drive(0, 3, 0, 3, 8, 2, 0, 0, 0);
      tick("lw2", s);
      drive(8, 0, 0, 3, 0, 0, 0, 0, 0);
      count_stalls("lw_beq", n);
      chk("lw_beq_stall_cycles", n, 2);
      nops(2);

      // add $t0 ; sw rt=$t0 -> no stall
      drive(0, 3, 0, 3, 8, 1, 0, 0, 0);
      tick("add", s);
      drive(0, 3, 8, 2, 0, 0, 0, 0, 0);
      count_stalls("add_sw", n);
      chk("add_sw_stall_cycles", n, 0);
      nops(2);

      // write to $0 ; reader of $0 with Tuse=0 -> no stall
      drive(0, 3, 0, 3, 0, 2, 0, 0, 0);
      tick("wr_zero", s);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      count_stalls("zero_reg", n);
      chk("zero_reg_stall_cycles", n, 0);
      nops(2);

      // div ; mflo -> 11 cycles
      drive(4, 1, 5, 1, 0, 0, 1, 1, 1);
      tick("div", s);
      drive(0, 3, 0, 3, 6, 1, 1, 0, 0);
      count_stalls("div_mflo", n);
      chk("div_mflo_stall_cycles", n, 11);
      nops(2);

      // mult ; mflo -> 6 cycles
      drive(4, 1, 5, 1, 0, 0, 1, 1, 0);
      tick("mult", s);
      drive(0, 3, 0, 3, 6, 1, 1, 0, 0);
      count_stalls("mult_mflo", n);
      chk("mult_mflo_stall_cycles", n, 6);
      nops(2);

      // Reset three cycles into a div window clears the busy count.
      drive(4, 1, 5, 1, 0, 0, 1, 1, 1);
      tick("div_r", s);
      drive(0, 3, 0, 3, 6, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick("div_r_busy", s);
      reset = 1'b1;
      tick("div_r_reset", s);
      reset = 1'b0;
      tick("mflo_after_reset", s);
      chk("mflo_after_reset_stall", int'(s), 0);
      nops(2);

      // Random traffic; stalled instructions usually hold their D inputs.
      hold = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!(hold && $urandom_range(0, 3) != 0)) begin
            bus.D_A1    = 5'($urandom_range(0, 3));
            bus.D_A2    = 5'($urandom_range(0, 3));
            bus.D_Tuse1 = 2'($urandom_range(0, 3));
            bus.D_Tuse2 = 2'($urandom_range(0, 3));
            bus.D_A3    = 5'($urandom_range(0, 3));
            bus.D_Tnew  = 2'($urandom_range(0, 2));
            bus.D_start = ($urandom_range(0, 11) == 0);
            bus.D_md    = bus.D_start | ($urandom_range(0, 5) == 0);
            bus.D_isdiv = 1'($urandom_range(0, 1));
         end
         tick("random", s);
         hold = s;
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
